// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide stage: op codes,
// FSM encoding and default widths.
package md_pkg;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_REG_ADDR_W = 3;

  typedef enum logic [1:0] {
    MD_MULLO = 2'b00,
    MD_MULHI = 2'b01,
    MD_DIV   = 2'b10,
    MD_MOD   = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_WB   = 2'b10
  } md_state_t;

  // DIV/MOD share op[1]=1; MULHI/MOD take the upper half of the accumulator.
  function automatic logic op_is_div(input md_op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/md_step.sv
// One radix-2 iteration: shift-add for multiply, compare-subtract-shift
// (restoring) for divide. Accumulator is {hi, lo}, each W bits.
module md_step
  import md_pkg::*;
#(
  parameter int W = DEF_WIDTH
) (
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   opnd,
  input  md_op_t         op,
  output logic [2*W-1:0] acc_next
);

  logic [W:0] sum;
  logic [W:0] shifted;
  logic [W:0] diff;

  always_comb begin
    sum      = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd : {W{1'b0}})};
    shifted  = acc[2*W-1:W-1];
    diff     = shifted - {1'b0, opnd};
    acc_next = {sum, acc[W-1:1]};
    if (op_is_div(op)) begin
      // Borrow out of the W+1-bit subtract means the divisor did not fit.
      if (!diff[W]) acc_next = {diff[W-1:0], acc[W-2:0], 1'b1};
      else          acc_next = {shifted[W-1:0], acc[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide stage: latches operands on start, runs
// WIDTH radix-2 steps, then issues a single register-file write.
module mul_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic [REG_ADDR_W-1:0] dest,
  output logic                  busy,
  output logic                  write,
  output logic [REG_ADDR_W-1:0] addw,
  output logic [WIDTH-1:0]      wd,
  output logic                  done,
  output logic                  div_zero
);

  localparam int CW = $clog2(WIDTH);

  md_state_t             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0]      b_q, b_d;
  md_op_t                op_q, op_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;
  logic [2*WIDTH-1:0]    acc_step;

  md_step #(.W(WIDTH)) u_step (
    .acc      (acc_q),
    .opnd     (b_q),
    .op       (op_q),
    .acc_next (acc_step)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    op_d    = op_q;
    dest_d  = dest_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Multiplier and dividend both start in the low half.
          acc_d   = {{WIDTH{1'b0}}, a};
          b_d     = b;
          op_d    = md_op_t'(op);
          dest_d  = dest;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = ST_WB;
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      op_q    <= MD_MULLO;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
    end
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    write    = (state_q == ST_WB);
    done     = write;
    addw     = write ? dest_q : '0;
    wd       = '0;
    div_zero = write && op_is_div(op_q) && (b_q == '0);
    if (write) wd = op_q[0] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: vector table plus
// hand-written sequences for busy-time start and mid-op reset.
module tb_mul_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a, b;
  logic [2:0]  dest;
  logic        busy, write, done, div_zero;
  logic [2:0]  addw;
  logic [15:0] wd;

  int checks   = 0;
  int failures = 0;

  mul_div_unit dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .dest(dest), .busy(busy), .write(write), .addw(addw), .wd(wd),
    .done(done), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  dest;
    logic [15:0] exp_wd;
    logic        exp_dz;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    bit seen = 0;
    int lat  = 0;
    @(negedge clock);
    start = 1'b1; op = v.op; a = v.a; b = v.b; dest = v.dest;
    @(posedge clock);
    #1;
    start = 1'b0;
    op = 2'($urandom); a = 16'($urandom); b = 16'($urandom); dest = 3'($urandom);
    chk({v.name, " busy_after_accept"}, 32'(busy), 32'd1);
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clock);
      if (write) begin
        seen = 1;
        lat  = k;
        chk({v.name, " wd"}, 32'(wd), 32'(v.exp_wd));
        chk({v.name, " addw"}, 32'(addw), 32'(v.dest));
        chk({v.name, " done"}, 32'(done), 32'd1);
        chk({v.name, " div_zero"}, 32'(div_zero), 32'(v.exp_dz));
      end
    end
    chk({v.name, " write_seen"}, 32'(seen), 32'd1);
    chk({v.name, " latency"}, 32'(lat), 32'd17);
    @(posedge clock);
    #1;
    chk({v.name, " busy_after_wb"}, 32'(busy), 32'd0);
    chk({v.name, " wd_idle"}, 32'(wd), 32'd0);
  endtask

  vec_t vecs[8];
  int   nwrites;
  logic [15:0] wd_seen;

  initial begin
    vecs[0] = '{"mullo_1234x10", 2'b00, 16'h1234, 16'h0010, 3'd3, 16'h2340, 1'b0};
    vecs[1] = '{"mulhi_1234x10", 2'b01, 16'h1234, 16'h0010, 3'd3, 16'h0001, 1'b0};
    vecs[2] = '{"mulhi_ffffxffff", 2'b01, 16'hFFFF, 16'hFFFF, 3'd1, 16'hFFFE, 1'b0};
    vecs[3] = '{"mullo_ffffxffff", 2'b00, 16'hFFFF, 16'hFFFF, 3'd2, 16'h0001, 1'b0};
    vecs[4] = '{"div_100_7", 2'b10, 16'd100, 16'd7, 3'd5, 16'd14, 1'b0};
    vecs[5] = '{"mod_100_7", 2'b11, 16'd100, 16'd7, 3'd5, 16'd2, 1'b0};
    vecs[6] = '{"div_by_zero", 2'b10, 16'h1234, 16'h0000, 3'd7, 16'hFFFF, 1'b1};
    vecs[7] = '{"mod_by_zero", 2'b11, 16'h1234, 16'h0000, 3'd6, 16'h1234, 1'b1};

    reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; dest = '0;
    #12;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_write", 32'(write), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_outs", {12'd0, div_zero, addw, wd}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) run_op(vecs[i]);

    // start pulses at cycle 5 and during WB (cycle 17) must be ignored
    nwrites = 0; wd_seen = '0;
    @(negedge clock);
    start = 1'b1; op = 2'b00; a = 16'd3; b = 16'd4; dest = 3'd4;
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (write) begin
        nwrites++;
        wd_seen = wd;
      end
      if (k == 17) chk("busy_start_wb_state", 32'(write), 32'd1);
      if (k == 5 || k == 17) begin
        start = 1'b1; op = 2'b10; a = 16'd9; b = 16'd3; dest = 3'd1;
      end else begin
        start = 1'b0;
      end
      if (k == 18) chk("busy_start_busy_drop", 32'(busy), 32'd0);
    end
    chk("busy_start_nwrites", 32'(nwrites), 32'd1);
    chk("busy_start_wd", 32'(wd_seen), 32'd12);

    // reset mid-DIV discards the op
    nwrites = 0;
    @(negedge clock);
    start = 1'b1; op = 2'b10; a = 16'd100; b = 16'd7; dest = 3'd2;
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      if (write) nwrites++;
    end
    reset = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_write_done", {30'd0, write, done}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (write || busy) nwrites++;
    end
    chk("midreset_no_write", 32'(nwrites), 32'd0);
    run_op('{"post_reset_mullo_2x3", 2'b00, 16'd2, 16'd3, 3'd0, 16'd6, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
